// File: rtl/bram_snapshot_ctrl.sv
// bram_snapshot_ctrl
//   Single-shot capture sequencer that drives the fabric write port of a BRAM.
//   Software arms the block and then triggers it, either directly or from a
//   rising edge on an external line. The incoming sample stream is then written
//   into the buffer until DEPTH = 2**ADDR_WIDTH samples are held. Software polls
//   state/done and reads the buffer back over its own port.
//
//   Optional feature macro: SNAP_PRETRIG_EN
//     When defined, the buffer runs as a ring while ARMED and keeps PRETRIG
//     samples of history ahead of the trigger sample.
//     When undefined, nothing is written while ARMED and the trigger sample
//     always lands at address 0.
//
// Ports
//   fpga_clk     capture / BRAM clock
//   rst          synchronous active-high reset
//   arm          pulse: start or restart a snapshot
//   abort        pulse: cancel and return to IDLE (wins over arm)
//   sw_trig      software trigger pulse
//   ext_trig     external trigger level; its rising edge is used
//   ext_trig_en  enables ext_trig
//   din          sample data
//   din_valid    sample qualifier
//   bram_addr    BRAM write address
//   bram_din     BRAM write data
//   bram_we      BRAM write enable
//   state        0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   done         snapshot complete; held until the next arm or abort
//   wr_count     samples written since the trigger, trigger sample included
//   trig_addr    BRAM address of the trigger sample
module bram_snapshot_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned PRETRIG    = 64
) (
  input  logic                  fpga_clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  sw_trig,
  input  logic                  ext_trig,
  input  logic                  ext_trig_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic                  bram_we,
  output logic [1:0]            state,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic [ADDR_WIDTH-1:0] trig_addr
);

  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
`ifdef SNAP_PRETRIG_EN
  localparam int unsigned CAP_LEN = DEPTH - PRETRIG;
`else
  // Without the pretrigger ring, PRETRIG has no effect on the capture length.
  localparam int unsigned CAP_LEN = DEPTH + (PRETRIG * 0);
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                fsm;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic                  ext_trig_q;
  logic                  trig;
  logic [CW-1:0]         count_inc;
  logic                  cap_last;
`ifdef SNAP_PRETRIG_EN
  logic [CW-1:0]         fill;
  logic                  fill_ok;
  assign fill_ok = (fill >= CW'(PRETRIG));
`endif

  assign trig      = sw_trig | (ext_trig_en & ext_trig & ~ext_trig_q);
  // Post-trigger count after accepting one more sample, saturating at DEPTH.
  assign count_inc = (wr_count == CW'(DEPTH)) ? wr_count : wr_count + CW'(1);
  assign cap_last  = (count_inc >= CW'(CAP_LEN));
  assign state     = fsm;

  // Sequencer: every write is registered, so a sample taken at cycle t shows up
  // on the BRAM port at cycle t+1.
  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      fsm        <= S_IDLE;
      wr_ptr     <= '0;
      ext_trig_q <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      done       <= 1'b0;
      wr_count   <= '0;
      trig_addr  <= '0;
`ifdef SNAP_PRETRIG_EN
      fill       <= '0;
`endif
    end else begin
      ext_trig_q <= ext_trig;
      bram_we    <= 1'b0;
      if (abort) begin
        fsm  <= S_IDLE;
        done <= 1'b0;
      end else if (arm) begin
        // Also covers trig in the same cycle: that trigger is dropped.
        fsm       <= S_ARMED;
        wr_ptr    <= '0;
        wr_count  <= '0;
        done      <= 1'b0;
        trig_addr <= '0;
`ifdef SNAP_PRETRIG_EN
        fill      <= '0;
`endif
      end else begin
        case (fsm)
          S_ARMED: begin
`ifdef SNAP_PRETRIG_EN
            // History ring: every sample is kept while waiting for a trigger.
            if (din_valid) begin
              bram_we   <= 1'b1;
              bram_addr <= wr_ptr;
              bram_din  <= din;
              wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
              if (fill != CW'(PRETRIG)) fill <= fill + CW'(1);
            end
            // Trigger only once enough history is present.
            if (trig && fill_ok) begin
              fsm       <= S_CAPTURE;
              trig_addr <= wr_ptr;
              if (din_valid) begin
                wr_count <= count_inc;
                if (cap_last) begin
                  fsm  <= S_DONE;
                  done <= 1'b1;
                end
              end
            end
`else
            if (trig) begin
              fsm <= S_CAPTURE;
              if (din_valid) begin
                bram_we   <= 1'b1;
                bram_addr <= wr_ptr;
                bram_din  <= din;
                wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
                wr_count  <= count_inc;
                if (cap_last) begin
                  fsm  <= S_DONE;
                  done <= 1'b1;
                end
              end
            end
`endif
          end
          S_CAPTURE: begin
            if (din_valid) begin
              bram_we   <= 1'b1;
              bram_addr <= wr_ptr;
              bram_din  <= din;
              wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
              wr_count  <= count_inc;
              if (cap_last) begin
                fsm  <= S_DONE;
                done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
